pic_cascade_master: RTL and testbench
=====================================

Name: pic_cascade_master

Overview:
- Parametrised, clocked master-side interrupt controller for cascaded PIC systems.
- Resolves priority among up to 8 IR inputs, any of which may be flagged as a cascaded slave.
- Runs the two-pulse INTA sequence and drives the cascade ID onto the shared cascade lines; drives the vector itself only for non-slave IRs.
- Adds masking, rotating priority, non-specific EOI and an INTA timeout on top of the earlier fixed master/slave arrangement.

Parameters:
- NUM_IR, 8, number of IR inputs; legal 2..8.
- CAS_W, 3, cascade ID width; must be >= clog2(NUM_IR).
- INTA_TIMEOUT, 16, cycles allowed between the two INTA pulses before abort; legal 2..255.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ir_req  in  NUM_IR  level-sensitive interrupt requests; slave INT outputs connect here.
- imr  in  NUM_IR  mask; 1 = IR blocked.
- slave_map  in  NUM_IR  1 = IR has a cascaded slave (ICW3 equivalent).
- vec_base  in  8  vector base; only bits [7:3] are used.
- rotate_en  in  1  1 = automatic rotating priority on EOI.
- inta_n  in  1  CPU acknowledge; active low, synchronous to clk.
- eoi  in  1  one-cycle non-specific EOI pulse.
- int_out  out  1  interrupt request to CPU.
- cas_out  out  CAS_W  cascade ID.
- cas_oe  out  1  cascade lines driven.
- vec_out  out  8  vector byte.
- vec_oe  out  1  vector valid / master drives data bus.
- isr  out  NUM_IR  in-service register.
- timeout_err  out  1  one-cycle pulse on INTA timeout.

Behaviour:
- Reset (async, any state): FSM=IDLE; all outputs 0; isr=0; lowest-priority pointer = NUM_IR-1 (IR0 highest).
- Pending set: P = ir_req & ~imr & ~isr. Priority order starts at (pointer+1) mod NUM_IR.
- Winner: the highest-priority bit of P. It is valid only if it outranks every set isr bit (fully nested).
- INTA edges: inta_n is registered once. Fall = prev 1 & cur 0. Rise = prev 0 & cur 1.
- IDLE:
  - Winner valid: int_out=1 on the next clk. Go to REQ.
- REQ:
  - Winner is re-evaluated every cycle.
  - Winner disappears: int_out stays 1 (spurious handled at ACK).
  - On fall, go to ACK1:
    - Latch win_idx and clear int_out.
    - If winner valid: set isr[win_idx].
    - If winner invalid: spurious; win_idx = NUM_IR-1, isr unchanged, treated as non-slave.
    - If slave_map[win_idx] and not spurious: cas_out=win_idx, cas_oe=1, both from the cycle after the fall.
- ACK1:
  - On rise, go to WAIT2 and clear the timeout counter.
- WAIT2:
  - Counter increments each cycle.
  - On fall, go to ACK2:
    - Slave case: vec_oe stays 0; cas lines are held.
    - Otherwise: vec_out = {vec_base[7:3], win_idx padded to 3 bits}, vec_oe=1.
  - Counter reaches INTA_TIMEOUT: go to IDLE, cas_oe=0, timeout_err pulses. The isr bit stays set and is released by EOI.
- ACK2:
  - On rise, go to IDLE the next cycle; cas_oe, vec_oe, vec_out and cas_out return to 0.
- Re-arm: int_out may re-assert in IDLE no earlier than 1 cycle after ACK2 exits.
- EOI: clears the highest-priority set isr bit. If rotate_en, that bit becomes the lowest-priority pointer. EOI with isr=0 is ignored.
- EOI coinciding with an ACK1 fall: EOI is applied first, then the winner is computed from the post-EOI isr.
- imr change during REQ only affects winner re-evaluation; a latched ACK is never altered.

Test Plan:
- Non-slave request: ir_req=8'h08, slave_map=0, vec_base=8'h40, two INTA pulses -> int_out 1 then 0; isr=8'h08; vec_out=8'h43 with vec_oe=1 during the 2nd pulse; cas_oe=0 throughout.
- Slave request: ir_req=8'h04, slave_map=8'h04 -> cas_out=3'd2, cas_oe=1 from the 1st fall until the 2nd rise; vec_oe never 1; isr=8'h04.
- Nesting: isr=8'h02, ir_req=8'h21 -> IR0 serviced (isr=8'h03); IR5 blocked until two EOIs clear isr; then IR5 serviced with vector base+5.
- Rotation: rotate_en=1, ir_req=8'hFF, repeated ACK + EOI -> service order 0,1,2,...,7,0.
- Spurious: ir_req pulses high only before the 1st INTA -> vector base+7, isr unchanged, int_out=0.
- Timeout: only the 1st INTA for a slave IR, INTA_TIMEOUT=16 -> timeout_err pulses 16 cycles after the rise, cas_oe=0, FSM in IDLE.
- Reset mid-operation: rst_n low during WAIT2 -> all outputs and isr are 0 immediately.

Source files
------------

// File: rtl/pic_cascade_master.sv
// pic_cascade_master: cascade-aware master PIC with masking, rotating priority,
// non-specific EOI and an abort when the second INTA never arrives.
module pic_cascade_master #(
    parameter int NUM_IR       = 8,
    parameter int CAS_W        = 3,
    parameter int INTA_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_IR-1:0] ir_req,
    input  logic [NUM_IR-1:0] imr,
    input  logic [NUM_IR-1:0] slave_map,
    input  logic [7:0]        vec_base,
    input  logic              rotate_en,
    input  logic              inta_n,
    input  logic              eoi,
    output logic              int_out,
    output logic [CAS_W-1:0]  cas_out,
    output logic              cas_oe,
    output logic [7:0]        vec_out,
    output logic              vec_oe,
    output logic [NUM_IR-1:0] isr,
    output logic              timeout_err
);
    typedef enum logic [2:0] {IDLE, REQ, ACK1, WAIT2, ACK2} state_t;

    state_t             st_q, st_d;
    logic               inta_q;
    logic               int_q, int_d;
    logic [CAS_W-1:0]   cas_q, cas_d;
    logic               cas_oe_q, cas_oe_d;
    logic [7:0]         vec_q, vec_d;
    logic               vec_oe_q, vec_oe_d;
    logic [NUM_IR-1:0]  isr_q, isr_d;
    logic               terr_q, terr_d;
    logic [2:0]         win_q, win_d;
    logic [2:0]         lp_q, lp_d;
    logic               slv_q, slv_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [NUM_IR-1:0]  isr_e, pend;
    logic [2:0]         lp_e, win;
    logic [3:0]         top_r, win_r, isr_r;
    logic               win_v, fall, rise, win_slv;
    logic               unused_ok;

    // Index of the IR holding priority rank k (rank 0 sits just above pointer lp).
    function automatic logic [2:0] rot(input logic [2:0] lp, input logic [3:0] k);
        int idx;
        idx = int'(lp) + int'(k) + 1;
        if (idx >= NUM_IR) idx = idx - NUM_IR;
        return 3'(idx);
    endfunction

    // Rank of the highest-priority set bit of v, NUM_IR when v is empty.
    function automatic logic [3:0] first_rank(input logic [NUM_IR-1:0] v, input logic [2:0] lp);
        logic [3:0] r;
        r = 4'(NUM_IR);
        for (int k = NUM_IR - 1; k >= 0; k--)
            if (v[rot(lp, 4'(k))]) r = 4'(k);
        return r;
    endfunction

    assign fall      = inta_q & ~inta_n;
    assign rise      = ~inta_q & inta_n;
    assign unused_ok = ^vec_base[2:0];

    // EOI is folded in first so a same-cycle acknowledge sees the post-EOI isr.
    always_comb begin
        top_r = first_rank(isr_q, lp_q);
        isr_e = isr_q;
        lp_e  = lp_q;
        if (eoi && top_r != 4'(NUM_IR)) begin
            isr_e[rot(lp_q, top_r)] = 1'b0;
            lp_e = rotate_en ? rot(lp_q, top_r) : lp_q;
        end
        pend    = ir_req & ~imr & ~isr_e;
        win_r   = first_rank(pend, lp_e);
        isr_r   = first_rank(isr_e, lp_e);
        win_v   = win_r < isr_r;
        win     = rot(lp_e, win_r);
        win_slv = win_v & slave_map[win];
    end

    always_comb begin
        st_d     = st_q;
        int_d    = int_q;
        cas_d    = cas_q;
        cas_oe_d = cas_oe_q;
        vec_d    = vec_q;
        vec_oe_d = vec_oe_q;
        isr_d    = isr_e;
        lp_d     = lp_e;
        terr_d   = 1'b0;
        win_d    = win_q;
        slv_d    = slv_q;
        cnt_d    = cnt_q;
        case (st_q)
            IDLE: if (win_v) begin
                int_d = 1'b1;
                st_d  = REQ;
            end
            REQ: if (fall) begin
                st_d     = ACK1;
                int_d    = 1'b0;
                win_d    = win_v ? win : 3'(NUM_IR - 1);
                slv_d    = win_slv;
                cas_d    = win_slv ? CAS_W'(win) : '0;
                cas_oe_d = win_slv;
                if (win_v) isr_d[win] = 1'b1;
            end
            ACK1: if (rise) begin
                st_d  = WAIT2;
                cnt_d = 8'd0;
            end
            WAIT2: begin
                cnt_d = cnt_q + 8'd1;
                if (fall) begin
                    st_d     = ACK2;
                    vec_d    = slv_q ? 8'h00 : {vec_base[7:3], win_q};
                    vec_oe_d = ~slv_q;
                end else if (cnt_q + 8'd1 == 8'(INTA_TIMEOUT)) begin
                    st_d     = IDLE;
                    cas_d    = '0;
                    cas_oe_d = 1'b0;
                    terr_d   = 1'b1;
                end
            end
            ACK2: if (rise) begin
                st_d     = IDLE;
                cas_d    = '0;
                cas_oe_d = 1'b0;
                vec_d    = 8'h00;
                vec_oe_d = 1'b0;
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q     <= IDLE;
            inta_q   <= 1'b1;
            int_q    <= 1'b0;
            cas_q    <= '0;
            cas_oe_q <= 1'b0;
            vec_q    <= 8'h00;
            vec_oe_q <= 1'b0;
            isr_q    <= '0;
            terr_q   <= 1'b0;
            win_q    <= 3'd0;
            lp_q     <= 3'(NUM_IR - 1);
            slv_q    <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            st_q     <= st_d;
            inta_q   <= inta_n;
            int_q    <= int_d;
            cas_q    <= cas_d;
            cas_oe_q <= cas_oe_d;
            vec_q    <= vec_d;
            vec_oe_q <= vec_oe_d;
            isr_q    <= isr_d;
            terr_q   <= terr_d;
            win_q    <= win_d;
            lp_q     <= lp_d;
            slv_q    <= slv_d;
            cnt_q    <= cnt_d;
        end
    end

    assign int_out     = int_q;
    assign cas_out     = cas_q;
    assign cas_oe      = cas_oe_q;
    assign vec_out     = vec_q;
    assign vec_oe      = vec_oe_q;
    assign isr         = isr_q;
    assign timeout_err = terr_q;
endmodule

// File: tb/tb_pic_cascade_master.sv
// tb_pic_cascade_master: directed scenarios for the cascade master PIC with
// hand-computed expectations.
module tb_pic_cascade_master;
    logic       clk, rst_n;
    logic [7:0] ir_req, imr, slave_map, vec_base;
    logic       rotate_en, inta_n, eoi;
    logic       int_out, cas_oe, vec_oe, timeout_err;
    logic [2:0] cas_out;
    logic [7:0] vec_out, isr;
    int         n_checks = 0;
    int         n_fail = 0;

    pic_cascade_master #(.NUM_IR(8), .CAS_W(3), .INTA_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .ir_req(ir_req), .imr(imr), .slave_map(slave_map),
        .vec_base(vec_base), .rotate_en(rotate_en), .inta_n(inta_n), .eoi(eoi),
        .int_out(int_out), .cas_out(cas_out), .cas_oe(cas_oe), .vec_out(vec_out),
        .vec_oe(vec_oe), .isr(isr), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pfall();
        inta_n = 1'b0;
        tick();
    endtask

    task automatic prise();
        inta_n = 1'b1;
        tick();
    endtask

    task automatic eoi_pulse();
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ir_req = 8'h00; imr = 8'h00; slave_map = 8'h00;
        vec_base = 8'h40; rotate_en = 1'b0; inta_n = 1'b1; eoi = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({int_out, cas_oe, vec_oe, timeout_err, cas_out, vec_out, isr} !== 23'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", {int_out, cas_oe, vec_oe, timeout_err, cas_out, vec_out, isr});
        end
    endtask

    task automatic test_nonslave();
        do_reset();
        ir_req = 8'h08;
        tick();
        n_checks++;
        if (int_out !== 1'b1) begin n_fail++; $display("FAIL ns_int: got %b want 1", int_out); end
        pfall();
        n_checks++;
        if ({int_out, cas_oe, isr} !== {1'b0, 1'b0, 8'h08}) begin
            n_fail++; $display("FAIL ns_ack1: int=%b cas_oe=%b isr=%h want 0 0 08", int_out, cas_oe, isr);
        end
        tick(); prise(); tick();
        pfall();
        n_checks++;
        if ({vec_oe, vec_out, cas_oe} !== {1'b1, 8'h43, 1'b0}) begin
            n_fail++; $display("FAIL ns_vector: vec_oe=%b vec=%h cas_oe=%b want 1 43 0", vec_oe, vec_out, cas_oe);
        end
        ir_req = 8'h00;
        prise();
        n_checks++;
        if ({vec_oe, vec_out, int_out} !== 10'h0) begin
            n_fail++; $display("FAIL ns_release: vec_oe=%b vec=%h int=%b want 0 00 0", vec_oe, vec_out, int_out);
        end
        eoi_pulse();
        n_checks++;
        if (isr !== 8'h00) begin n_fail++; $display("FAIL ns_eoi: isr=%h want 00", isr); end
    endtask

    task automatic test_slave();
        do_reset();
        ir_req = 8'h04; slave_map = 8'h04;
        tick();
        pfall();
        n_checks++;
        if ({cas_oe, cas_out, vec_oe, isr} !== {1'b1, 3'd2, 1'b0, 8'h04}) begin
            n_fail++; $display("FAIL sl_cas: cas_oe=%b cas=%0d vec_oe=%b isr=%h want 1 2 0 04", cas_oe, cas_out, vec_oe, isr);
        end
        prise(); tick();
        pfall();
        n_checks++;
        if ({cas_oe, cas_out, vec_oe} !== {1'b1, 3'd2, 1'b0}) begin
            n_fail++; $display("FAIL sl_ack2: cas_oe=%b cas=%0d vec_oe=%b want 1 2 0", cas_oe, cas_out, vec_oe);
        end
        prise();
        n_checks++;
        if ({cas_oe, cas_out, vec_oe} !== 5'h0) begin
            n_fail++; $display("FAIL sl_release: cas_oe=%b cas=%0d vec_oe=%b want 0 0 0", cas_oe, cas_out, vec_oe);
        end
    endtask

    task automatic test_nesting();
        do_reset();
        ir_req = 8'h02;
        tick(); pfall(); prise(); pfall(); prise();
        ir_req = 8'h21;
        tick();
        n_checks++;
        if (int_out !== 1'b1) begin n_fail++; $display("FAIL nest_ir0_int: got %b want 1", int_out); end
        pfall(); prise(); pfall();
        n_checks++;
        if ({isr, vec_out} !== {8'h03, 8'h40}) begin
            n_fail++; $display("FAIL nest_ir0: isr=%h vec=%h want 03 40", isr, vec_out);
        end
        ir_req = 8'h20;
        prise(); tick();
        n_checks++;
        if (int_out !== 1'b0) begin n_fail++; $display("FAIL nest_blocked: int=%b want 0", int_out); end
        eoi_pulse();
        n_checks++;
        if ({isr, int_out} !== {8'h02, 1'b0}) begin
            n_fail++; $display("FAIL nest_eoi1: isr=%h int=%b want 02 0", isr, int_out);
        end
        eoi_pulse();
        n_checks++;
        if ({isr, int_out} !== {8'h00, 1'b1}) begin
            n_fail++; $display("FAIL nest_eoi2: isr=%h int=%b want 00 1", isr, int_out);
        end
        pfall(); prise(); pfall();
        n_checks++;
        if ({vec_out, isr} !== {8'h45, 8'h20}) begin
            n_fail++; $display("FAIL nest_ir5: vec=%h isr=%h want 45 20", vec_out, isr);
        end
        prise();
    endtask

    task automatic test_rotation();
        logic [7:0] exp_vec;
        do_reset();
        rotate_en = 1'b1; ir_req = 8'hFF;
        tick();
        for (int i = 0; i < 9; i++) begin
            exp_vec = 8'h40 + 8'(i % 8);
            n_checks++;
            if (int_out !== 1'b1) begin n_fail++; $display("FAIL rot_int[%0d]: got %b want 1", i, int_out); end
            pfall(); prise(); pfall();
            n_checks++;
            if (vec_out !== exp_vec) begin n_fail++; $display("FAIL rot_vec[%0d]: got %h want %h", i, vec_out, exp_vec); end
            prise();
            eoi_pulse();
        end
    endtask

    task automatic test_spurious();
        do_reset();
        ir_req = 8'h10;
        tick();
        ir_req = 8'h00;
        pfall();
        n_checks++;
        if ({int_out, isr} !== 9'h0) begin n_fail++; $display("FAIL spur_ack1: int=%b isr=%h want 0 00", int_out, isr); end
        prise(); pfall();
        n_checks++;
        if ({vec_oe, vec_out, cas_oe, isr} !== {1'b1, 8'h47, 1'b0, 8'h00}) begin
            n_fail++; $display("FAIL spur_vec: vec_oe=%b vec=%h cas_oe=%b isr=%h want 1 47 0 00", vec_oe, vec_out, cas_oe, isr);
        end
        prise();
    endtask

    task automatic test_mask();
        do_reset();
        imr = 8'h01; ir_req = 8'h01;
        tick(); tick();
        n_checks++;
        if (int_out !== 1'b0) begin n_fail++; $display("FAIL mask_block: int=%b want 0", int_out); end
        imr = 8'h00;
        tick();
        n_checks++;
        if (int_out !== 1'b1) begin n_fail++; $display("FAIL mask_release: int=%b want 1", int_out); end
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        ir_req = 8'h04; slave_map = 8'h04;
        tick(); pfall();
        ir_req = 8'h00;
        inta_n = 1'b1;
        n = 0;
        // Rise is registered on the first edge; the abort lands 16 cycles later.
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (timeout_err === 1'b1) begin n = i; break; end
        end
        n_checks++;
        if (n !== 17) begin n_fail++; $display("FAIL to_latency: got %0d edges want 17", n); end
        n_checks++;
        if ({cas_oe, cas_out, int_out, isr} !== {1'b0, 3'd0, 1'b0, 8'h04}) begin
            n_fail++; $display("FAIL to_state: cas_oe=%b cas=%0d int=%b isr=%h want 0 0 0 04", cas_oe, cas_out, int_out, isr);
        end
        tick();
        n_checks++;
        if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_pulse: got %b want 0", timeout_err); end
        eoi_pulse();
        ir_req = 8'h01;
        tick();
        n_checks++;
        if ({int_out, isr} !== {1'b1, 8'h00}) begin
            n_fail++; $display("FAIL to_idle: int=%b isr=%h want 1 00", int_out, isr);
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        ir_req = 8'h04; slave_map = 8'h04;
        tick(); pfall(); prise(); tick();
        n_checks++;
        if ({cas_oe, isr} !== {1'b1, 8'h04}) begin
            n_fail++; $display("FAIL mid_pre: cas_oe=%b isr=%h want 1 04", cas_oe, isr);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({int_out, cas_oe, vec_oe, timeout_err, cas_out, vec_out, isr} !== 23'h0) begin
            n_fail++; $display("FAIL mid_reset: got %h want 0", {int_out, cas_oe, vec_oe, timeout_err, cas_out, vec_out, isr});
        end
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_nonslave();
        test_slave();
        test_nesting();
        test_rotation();
        test_spurious();
        test_mask();
        test_timeout();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
